// File: rtl/xmit_pkg.sv
// Shared constants for the transmit frame queue: RAM geometry, control-block
// layout and write-FSM state encodings.
package xmit_pkg;
  localparam int ADDR_W     = 12;
  localparam int RAM_DEPTH  = 1 << ADDR_W;
  localparam int CTRL_DEPTH = 16;
  localparam int CNT_W      = 16;
  localparam int CTRL_W     = 24;
  localparam int LEN_MSB    = 23;
  localparam int LEN_LSB    = 12;
  localparam int ADDR_MSB   = 11;
  localparam int ADDR_LSB   = 0;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_RECV    = 2'd1;
  localparam logic [1:0] ST_DISCARD = 2'd2;

  function automatic logic [CTRL_W-1:0] pack_ctrl(input logic [ADDR_W-1:0] len,
                                                  input logic [ADDR_W-1:0] start);
    return {len, start};
  endfunction
endpackage

// File: rtl/xmit_ctrl_fifo.sv
// Show-ahead synchronous FIFO of frame control blocks; head reads as zero
// while empty so the consumer sees a clean bus.
module xmit_ctrl_fifo #(
  parameter int W     = 24,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [W-1:0]             push_data,
  input  logic                     pop,
  output logic [W-1:0]             head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int PW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wptr;
  logic [PW-1:0] rptr;
  logic          do_push;
  logic          do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign full    = (count == (PW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign head    = empty ? '0 : mem[rptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= push_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (!do_push && do_pop) count <= count - 1'b1;
    end
  end
endmodule

// File: rtl/xmit_frame_queue.sv
// Transmit frame store: circular byte RAM filled by the switch core, one control
// block per committed frame, bytes served to out_FSM by offset, space freed on pop.
module xmit_frame_queue
  import xmit_pkg::*;
(
  input  logic              clk_phy,
  input  logic              reset_n,
  input  logic              wr_en_in,
  input  logic [7:0]        wr_data_in,
  input  logic              wr_sof_in,
  input  logic              wr_eof_in,
  output logic [CTRL_W-1:0] ctrl_block_out,
  output logic              ctrl_valid_out,
  input  logic [ADDR_W-1:0] frame_seq_in,
  input  logic              xmit_done_in,
  output logic [7:0]        data_out,
  output logic [4:0]        frames_queued_out,
  output logic [ADDR_W:0]   free_bytes_out,
  output logic [CNT_W-1:0]  drop_cnt_out,
  output logic [1:0]        state_dbg
);
  // Handshake: ctrl_valid_out high means ctrl_block_out is a committed frame;
  // a one-cycle xmit_done_in while valid pops it, while not valid it is ignored.
  logic [1:0]        state, state_n;
  logic [ADDR_W-1:0] wptr, wptr_n, frame_start, start_n, len, len_n;
  logic [ADDR_W-1:0] waddr, restore, sof_base, raddr, pop_len;
  logic [ADDR_W:0]   free_bytes, free_avail;
  logic [CNT_W-1:0]  drop_cnt;
  logic              wr, commit, drop, take_sof, pop;
  logic              fifo_full, fifo_empty;
  logic [CTRL_W-1:0] fifo_head;
  logic [7:0]        ram [RAM_DEPTH];

  always_comb begin
    state_n    = state;
    wptr_n     = wptr;
    start_n    = frame_start;
    len_n      = len;
    wr         = 1'b0;
    waddr      = wptr;
    commit     = 1'b0;
    drop       = 1'b0;
    restore    = '0;
    take_sof   = 1'b0;
    sof_base   = wptr;
    free_avail = free_bytes;
    if (wr_en_in) begin
      case (state)
        ST_RECV: begin
          if (wr_sof_in) begin
            // Abort the open frame and restart from its start in the same beat.
            restore    = len;
            drop       = 1'b1;
            take_sof   = 1'b1;
            sof_base   = frame_start;
            free_avail = free_bytes + {1'b0, len};
          end else if (free_bytes == '0 || len == '1) begin
            restore = len;
            drop    = 1'b1;
            wptr_n  = frame_start;
            state_n = wr_eof_in ? ST_IDLE : ST_DISCARD;
          end else begin
            wr     = 1'b1;
            waddr  = wptr;
            wptr_n = wptr + 1'b1;
            len_n  = len + 1'b1;
            if (wr_eof_in) begin
              commit  = 1'b1;
              state_n = ST_IDLE;
            end
          end
        end
        default: begin
          if (wr_sof_in) take_sof = 1'b1;
          else if (state == ST_DISCARD && wr_eof_in) state_n = ST_IDLE;
        end
      endcase
      if (take_sof) begin
        if (fifo_full || free_avail == '0) begin
          drop    = 1'b1;
          wptr_n  = sof_base;
          state_n = wr_eof_in ? ST_IDLE : ST_DISCARD;
        end else begin
          wr      = 1'b1;
          waddr   = sof_base;
          start_n = sof_base;
          wptr_n  = sof_base + 1'b1;
          len_n   = ADDR_W'(1);
          commit  = wr_eof_in;
          state_n = wr_eof_in ? ST_IDLE : ST_RECV;
        end
      end
    end
  end

  assign pop     = xmit_done_in && ctrl_valid_out;
  assign pop_len = pop ? fifo_head[LEN_MSB:LEN_LSB] : '0;

  always_ff @(posedge clk_phy or negedge reset_n) begin
    if (!reset_n) begin
      state       <= ST_IDLE;
      wptr        <= '0;
      frame_start <= '0;
      len         <= '0;
      free_bytes  <= (ADDR_W+1)'(RAM_DEPTH);
      drop_cnt    <= '0;
    end else begin
      state       <= state_n;
      wptr        <= wptr_n;
      frame_start <= start_n;
      len         <= len_n;
      free_bytes  <= free_bytes + {1'b0, restore} + {1'b0, pop_len} - {{ADDR_W{1'b0}}, wr};
      if (drop && drop_cnt != '1) drop_cnt <= drop_cnt + 1'b1;
    end
  end

  xmit_ctrl_fifo #(.W(CTRL_W), .DEPTH(CTRL_DEPTH)) u_ctrl_fifo (
    .clk       (clk_phy),
    .rst_n     (reset_n),
    .push      (commit),
    .push_data (pack_ctrl(len_n, start_n)),
    .pop       (pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (frames_queued_out)
  );

  // Read-during-write returns the old byte; committed bytes are never rewritten.
  assign raddr = fifo_head[ADDR_MSB:ADDR_LSB] + frame_seq_in;

  always_ff @(posedge clk_phy) begin
    if (wr) ram[waddr] <= wr_data_in;
  end

  always_ff @(posedge clk_phy or negedge reset_n) begin
    if (!reset_n) data_out <= '0;
    else          data_out <= ram[raddr];
  end

  assign ctrl_block_out = fifo_head;
  assign ctrl_valid_out = !fifo_empty;
  assign free_bytes_out = free_bytes;
  assign drop_cnt_out   = drop_cnt;
  assign state_dbg      = state;
endmodule
